// File: rtl/beat_pkg.sv
// Shared types, default sizes and round-robin helper for the beat scheduler.
package beat_pkg;

  localparam int unsigned DEF_STEPS = 12;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_CH_W  = $clog2(DEF_NCH);

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    ISSUE,
    WAIT
  } state_t;

  // First set bit of mask at or after ptr, wrapping; 0 when mask is empty.
  function automatic logic [DEF_CH_W-1:0] rr_pick(input logic [DEF_NCH-1:0] mask,
                                                   input logic [DEF_CH_W-1:0] ptr);
    logic [DEF_CH_W-1:0] idx;
    rr_pick = '0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int i = DEF_NCH - 1; i >= 0; i--) begin
      idx = DEF_CH_W'((int'(ptr) + i) % DEF_NCH);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/beat_scheduler_if.sv
// GO/sound_select/done handshake between the scheduler and the SD-card loader.
interface beat_scheduler_if;

  logic       go;
  logic [3:0] sound_select;
  logic       load_done;
  logic       load_error;

  modport master (output go, sound_select, input load_done, load_error);
  modport slave  (input go, sound_select, output load_done, load_error);

endinterface

// File: rtl/beat_scheduler_rr_arbiter.sv
// Combinational round-robin selector over the pending-hit mask.
module rr_arbiter
  import beat_pkg::*;
#(
  parameter  int unsigned N  = DEF_NCH,
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [CW-1:0] ptr,
  output logic [CW-1:0] grant,
  output logic          valid
);

  assign valid = |mask;

  if (N == DEF_NCH) begin : g_pkg
    assign grant = rr_pick(mask, ptr);
  end else begin : g_gen
    // Generic wrap-around search for non-default channel counts.
    always_comb begin
      grant = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (mask[CW'((int'(ptr) + i) % N)]) grant = CW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Step sequencer that issues each step's channel hits to the sample loader in round-robin order.
module beat_scheduler
  import beat_pkg::*;
#(
  parameter int unsigned STEPS          = DEF_STEPS,
  parameter int unsigned NCH            = DEF_NCH,
  parameter int unsigned SOUND_OFFSET   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step_tick,
  input  logic                      pause,
  input  logic [NCH-1:0][STEPS-1:0] pattern,
  beat_scheduler_if.master          loader,
  output logic [3:0]                step_idx,
  output logic                      busy,
  output logic [7:0]                overrun_cnt,
  output logic [7:0]                timeout_cnt
);

  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LAST = STEPS - 1;

  state_t          state, state_d;
  logic [NCH-1:0]  pending, pending_d, pend_left, clr;
  logic [CW-1:0]   rr_ptr, rr_d, sel_ch, sel_d, rr_next, grant;
  logic            valid;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [3:0]      step_d, next_step, ss_d;
  logic [7:0]      ovr_d, tmo_d;
  logic [8:0]      ovr_sum;
  logic            go_d, busy_d, advance;

  rr_arbiter #(.N(NCH)) u_arb (
    .mask  (pending),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (valid)
  );

  // Next-state, pending-mask and counter update logic.
  always_comb begin
    state_d   = state;
    pending_d = pending;
    rr_d      = rr_ptr;
    sel_d     = sel_ch;
    tcnt_d    = tcnt;
    step_d    = step_idx;
    ss_d      = loader.sound_select;
    ovr_d     = overrun_cnt;
    tmo_d     = timeout_cnt;
    go_d      = 1'b0;
    clr       = '0;
    ovr_sum   = '0;

    advance   = step_tick & ~pause;
    next_step = (step_idx == 4'(LAST)) ? 4'd0 : step_idx + 4'd1;
    rr_next   = (sel_ch == CW'(NCH - 1)) ? '0 : sel_ch + CW'(1);

    // The bit granted this cycle is consumed, so it is never counted as dropped.
    if (state == PICK && valid) clr = NCH'(1) << grant;
    pend_left = pending & ~clr;
    pending_d = pend_left;

    if (advance) begin
      step_d  = next_step;
      ovr_sum = {1'b0, overrun_cnt};
      for (int c = 0; c < NCH; c++) begin
        pending_d[CW'(c)] = pattern[CW'(c)][next_step];
        ovr_sum           = ovr_sum + 9'(pend_left[CW'(c)]);
      end
      ovr_d = (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];
    end

    case (state)
      IDLE: begin
        if (pending_d != '0) state_d = PICK;
      end
      PICK: begin
        if (valid) begin
          sel_d   = grant;
          ss_d    = 4'(SOUND_OFFSET + 32'(grant));
          go_d    = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (loader.load_done | loader.load_error) begin
          rr_d    = rr_next;
          state_d = IDLE;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rr_d    = rr_next;
          state_d = IDLE;
          if (timeout_cnt != 8'hFF) tmo_d = timeout_cnt + 8'd1;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || (state_d == WAIT);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      pending             <= '0;
      rr_ptr              <= '0;
      sel_ch              <= '0;
      tcnt                <= '0;
      step_idx            <= 4'(LAST);
      overrun_cnt         <= '0;
      timeout_cnt         <= '0;
      busy                <= 1'b0;
      loader.go           <= 1'b0;
      loader.sound_select <= '0;
    end else begin
      state               <= state_d;
      pending             <= pending_d;
      rr_ptr              <= rr_d;
      sel_ch              <= sel_d;
      tcnt                <= tcnt_d;
      step_idx            <= step_d;
      overrun_cnt         <= ovr_d;
      timeout_cnt         <= tmo_d;
      busy                <= busy_d;
      loader.go           <= go_d;
      loader.sound_select <= ss_d;
    end
  end

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed bench for beat_scheduler with a sound_select scoreboard.
module tb_beat_scheduler;

  localparam int unsigned TMO = 100;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             step_tick = 1'b0;
  logic             pause     = 1'b0;
  logic [3:0][11:0] pattern   = '0;
  logic [3:0]       step_idx;
  logic             busy;
  logic [7:0]       overrun_cnt;
  logic [7:0]       timeout_cnt;

  beat_scheduler_if ifc ();

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int go_count = 0;
  int exp_step = 11;
  int exp_ss[$];

  beat_scheduler #(
    .STEPS          (12),
    .NCH            (4),
    .SOUND_OFFSET   (0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_tick   (step_tick),
    .pause       (pause),
    .pattern     (pattern),
    .loader      (ifc),
    .step_idx    (step_idx),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_cnt (timeout_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ifc.go === 1'b1) go_count <= go_count + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    exp_step = 11;
  endtask

  task automatic tick(output int t0);
    step_tick = 1'b1;
    t0        = cyc;
    @(negedge clk);
    step_tick = 1'b0;
    if (!pause) exp_step = (exp_step == 11) ? 0 : exp_step + 1;
  endtask

  task automatic pulse_done(output int u);
    ifc.load_done = 1'b1;
    u             = cyc;
    @(negedge clk);
    ifc.load_done = 1'b0;
  endtask

  task automatic wait_go(output int g, output bit found);
    found = 1'b0;
    g     = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.go === 1'b1) begin
        found = 1'b1;
        g     = cyc;
        break;
      end
    end
  endtask

  task automatic pop_chk(input string tag);
    int e;
    chk({tag, "_sb_pending"}, int'(exp_ss.size() > 0), 1);
    if (exp_ss.size() > 0) begin
      e = exp_ss.pop_front();
      chk(tag, int'(ifc.sound_select), e);
    end
  endtask

  // Serve n loads, answering each go with load_done gap cycles later.
  task automatic serve(input int n, input int gap);
    int g, u;
    bit found;
    u = -1;
    for (int i = 0; i < n; i++) begin
      wait_go(g, found);
      chk("go_seen", int'(found), 1);
      if (!found) return;
      pop_chk("sound_select");
      if (u >= 0) chk("done_to_go", g - u, 3);
      repeat (gap) @(negedge clk);
      pulse_done(u);
    end
  endtask

  initial begin
    int  t0, g, g2, u, gc0;
    bit  found;

    ifc.load_done  = 1'b0;
    ifc.load_error = 1'b0;

    // Reset values
    do_reset();
    chk("rst_step_idx", int'(step_idx), 11);
    chk("rst_go", int'(ifc.go), 0);
    chk("rst_sound_select", int'(ifc.sound_select), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun_cnt), 0);
    chk("rst_timeout", int'(timeout_cnt), 0);

    // Single hit on channel 0 at step 0
    pattern    = '0;
    pattern[0] = 12'h001;
    exp_ss.push_back(0);
    gc0 = go_count;
    tick(t0);
    chk("first_step_idx", int'(step_idx), 0);
    wait_go(g, found);
    chk("first_go_seen", int'(found), 1);
    chk("first_go_latency", g - t0, 2);
    pop_chk("first_sound_select");
    repeat (10) @(negedge clk);
    pulse_done(u);
    chk("first_busy_after_done", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("first_go_count", go_count - gc0, 1);

    // All four channels on two consecutive steps
    do_reset();
    pattern = {4{12'hFFF}};
    for (int c = 0; c < 4; c++) exp_ss.push_back(c);
    tick(t0);
    serve(4, 5);
    for (int c = 0; c < 4; c++) exp_ss.push_back(c);
    tick(t0);
    serve(4, 5);

    // Round-robin pointer carries across steps
    pattern    = '0;
    pattern[0] = 12'hFFF;
    pattern[1] = 12'hFFF;
    exp_ss.push_back(0);
    exp_ss.push_back(1);
    tick(t0);
    serve(2, 5);
    pattern    = '0;
    pattern[1] = 12'hFFF;
    pattern[3] = 12'hFFF;
    exp_ss.push_back(3);
    exp_ss.push_back(1);
    tick(t0);
    serve(2, 5);
    chk("no_overrun_yet", int'(overrun_cnt), 0);

    // Empty patterns: step index walks and wraps, no go
    do_reset();
    pattern = '0;
    gc0     = go_count;
    for (int i = 0; i < 13; i++) begin
      tick(t0);
      chk("walk_step_idx", int'(step_idx), exp_step);
    end
    repeat (5) @(negedge clk);
    chk("walk_no_go", go_count - gc0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(t0);
      repeat (2) @(negedge clk);
    end
    chk("pause_hold_step_idx", int'(step_idx), exp_step);
    pause = 1'b0;

    // Pending hit still drains while paused
    pattern[2] = 12'hFFF;
    exp_ss.push_back(2);
    tick(t0);
    pause = 1'b1;
    serve(1, 5);
    pause = 1'b0;

    // New step during WAIT drops the remaining hits
    do_reset();
    pattern = {4{12'hFFF}};
    exp_ss.push_back(0);
    gc0 = go_count;
    tick(t0);
    wait_go(g, found);
    chk("ovr_go_seen", int'(found), 1);
    pop_chk("ovr_sound_select");
    @(negedge clk);
    pattern = '0;
    tick(t0);
    chk("overrun_cnt", int'(overrun_cnt), 3);
    repeat (10) @(negedge clk);
    pulse_done(u);
    repeat (20) @(negedge clk);
    chk("ovr_go_count", go_count - gc0, 1);
    chk("ovr_busy_idle", int'(busy), 0);

    // Loader never answers: timeout, then next channel
    do_reset();
    pattern    = '0;
    pattern[0] = 12'hFFF;
    pattern[1] = 12'hFFF;
    exp_ss.push_back(0);
    exp_ss.push_back(1);
    tick(t0);
    wait_go(g, found);
    chk("tmo_go_seen", int'(found), 1);
    pop_chk("tmo_sound_select");
    while (cyc < g + int'(TMO)) @(negedge clk);
    chk("tmo_before", int'(timeout_cnt), 0);
    chk("tmo_busy_before", int'(busy), 1);
    @(negedge clk);
    chk("tmo_after", int'(timeout_cnt), 1);
    chk("tmo_busy_after", int'(busy), 0);
    wait_go(g2, found);
    chk("tmo_next_go_seen", int'(found), 1);
    chk("tmo_next_go_latency", g2 - g, int'(TMO) + 3);
    pop_chk("tmo_next_sound_select");

    // Reset in the middle of WAIT
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_go", int'(ifc.go), 0);
    chk("mid_rst_sound_select", int'(ifc.sound_select), 0);
    chk("mid_rst_step_idx", int'(step_idx), 11);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun_cnt), 0);
    chk("mid_rst_timeout", int'(timeout_cnt), 0);
    reset    = 1'b0;
    exp_step = 11;
    gc0      = go_count;
    repeat (20) @(negedge clk);
    chk("post_rst_no_go", go_count - gc0, 0);
    chk("sb_empty", exp_ss.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
